div_seq: RTL and testbench

Multi-cycle iterative divider with sequencing controller for the execute stage. Fills the div slot of the execute-stage opcode decode. It accepts one divide from ID, stalls ID while it iterates one quotient bit per cycle, then presents a single-cycle result (rd number, data, flags) for merge into the register-file writeback path.

---
 rtl/div_seq_if.sv | 34 +++
 rtl/div_seq.sv | 175 +++++++++++++++++
 tb/tb_div_seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// ID-to-divider request bus and divider-to-writeback result bus.
// The slave side belongs to div_seq; the master side belongs to whoever drives ID.
interface div_seq_if #(
   parameter int WORD     = 32,
   parameter int W_RD     = 5,
   parameter int W_STATUS = 4
);
   logic                v_i;
   logic                div_i;
   logic                sgn_i;
   logic                rem_i;
   logic [WORD-1:0]     dest_i;
   logic [WORD-1:0]     src_i;
   logic                wb_i;
   logic [W_RD-1:0]     rd_num_i;
   logic                kill_i;
   logic                stall_o;
   logic                busy_o;
   logic                done_o;
   logic                wb_o;
   logic [W_RD-1:0]     rd_num_o;
   logic [WORD-1:0]     rd_data_o;
   logic [W_STATUS-1:0] status_o;

   modport master (
      output v_i, div_i, sgn_i, rem_i, dest_i, src_i, wb_i, rd_num_i, kill_i,
      input  stall_o, busy_o, done_o, wb_o, rd_num_o, rd_data_o, status_o
   );

   modport slave (
      input  v_i, div_i, sgn_i, rem_i, dest_i, src_i, wb_i, rd_num_i, kill_i,
      output stall_o, busy_o, done_o, wb_o, rd_num_o, rd_data_o, status_o
   );
endinterface

// File: rtl/div_seq.sv
// Iterative restoring divider for the execute-stage div slot.
// Produces one quotient bit per cycle, then a one-cycle writeback result.
module div_seq #(
   parameter int WORD     = 32,
   parameter int W_RD     = 5,
   parameter int W_STATUS = 4
) (
   input logic      clk,
   input logic      rst,
   div_seq_if.slave bus
);
   localparam int CNT_W = $clog2(WORD);
   localparam logic [WORD-1:0] MIN_VAL  = {1'b1, {(WORD-1){1'b0}}};
   localparam logic [WORD-1:0] ONES_VAL = {WORD{1'b1}};
   localparam logic [WORD-1:0] ZERO_VAL = {WORD{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      P_NORM = 2'd0,
      P_DZ   = 2'd1,
      P_OVF  = 2'd2
   } path_t;

   function automatic logic [WORD-1:0] neg_if(input logic [WORD-1:0] x, input logic en);
      return en ? (~x + {{(WORD-1){1'b0}}, 1'b1}) : x;
   endfunction

   function automatic logic [3:0] flags_of(input logic [WORD-1:0] d, input logic v, input logic dz);
      return {d[WORD-1], (d == ZERO_VAL), v, dz};
   endfunction

   state_t              state_q;
   path_t               path_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WORD-1:0]     dest_q, src_q, dmag_q, quo_q, prem_q;
   logic                sgn_q, rem_sel_q, wb_q, qneg_q, rneg_q;
   logic [W_RD-1:0]     rd_lat_q;
   logic [W_RD-1:0]     rd_num_q;
   logic [WORD-1:0]     rd_data_q;
   logic [W_STATUS-1:0] status_q;
   logic                done_q, wb_out_q;

   logic                accept;
   logic [WORD:0]       shifted;
   logic [WORD+1:0]     diff;
   logic [WORD-1:0]     prem_d, quo_d, res_d;

   // Accept decode, one restoring step, and final result selection.
   always_comb begin
      accept  = bus.v_i & bus.div_i & ~bus.kill_i & ((state_q == S_IDLE) | (state_q == S_DONE));
      shifted = {prem_q, quo_q[WORD-1]};
      diff    = {1'b0, shifted} - {2'b00, dmag_q};
      // A negative trial difference means the shifted remainder already fits in WORD bits.
      if (diff[WORD+1]) begin
         prem_d = shifted[WORD-1:0];
         quo_d  = {quo_q[WORD-2:0], 1'b0};
      end else begin
         prem_d = diff[WORD-1:0];
         quo_d  = {quo_q[WORD-2:0], 1'b1};
      end
      case (path_q)
         P_DZ:    res_d = rem_sel_q ? dest_q : ONES_VAL;
         P_OVF:   res_d = rem_sel_q ? ZERO_VAL : MIN_VAL;
         default: res_d = rem_sel_q ? neg_if(prem_q, rneg_q) : neg_if(quo_q, qneg_q);
      endcase
   end

   // Sequencing FSM with datapath and registered writeback outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         path_q    <= P_NORM;
         cnt_q     <= {CNT_W{1'b0}};
         dest_q    <= ZERO_VAL;
         src_q     <= ZERO_VAL;
         dmag_q    <= ZERO_VAL;
         quo_q     <= ZERO_VAL;
         prem_q    <= ZERO_VAL;
         sgn_q     <= 1'b0;
         rem_sel_q <= 1'b0;
         wb_q      <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         rd_lat_q  <= {W_RD{1'b0}};
         rd_num_q  <= {W_RD{1'b0}};
         rd_data_q <= ZERO_VAL;
         status_q  <= {W_STATUS{1'b0}};
         done_q    <= 1'b0;
         wb_out_q  <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         wb_out_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  dest_q    <= bus.dest_i;
                  src_q     <= bus.src_i;
                  sgn_q     <= bus.sgn_i;
                  rem_sel_q <= bus.rem_i;
                  wb_q      <= bus.wb_i;
                  rd_lat_q  <= bus.rd_num_i;
                  state_q   <= S_PREP;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_PREP: begin
               if (bus.kill_i) begin
                  state_q <= S_IDLE;
               end else begin
                  dmag_q <= neg_if(src_q, sgn_q & src_q[WORD-1]);
                  quo_q  <= neg_if(dest_q, sgn_q & dest_q[WORD-1]);
                  qneg_q <= sgn_q & (dest_q[WORD-1] ^ src_q[WORD-1]);
                  rneg_q <= sgn_q & dest_q[WORD-1];
                  prem_q <= ZERO_VAL;
                  cnt_q  <= CNT_W'(WORD - 1);
                  if (src_q == ZERO_VAL) begin
                     path_q  <= P_DZ;
                     state_q <= S_FIX;
                  end else if (sgn_q && (dest_q == MIN_VAL) && (src_q == ONES_VAL)) begin
                     path_q  <= P_OVF;
                     state_q <= S_FIX;
                  end else begin
                     path_q  <= P_NORM;
                     state_q <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               if (bus.kill_i) begin
                  state_q <= S_IDLE;
               end else begin
                  prem_q <= prem_d;
                  quo_q  <= quo_d;
                  if (cnt_q == {CNT_W{1'b0}}) begin
                     state_q <= S_FIX;
                  end else begin
                     cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            S_FIX: begin
               if (bus.kill_i) begin
                  state_q <= S_IDLE;
               end else begin
                  rd_data_q <= res_d;
                  status_q  <= flags_of(res_d, path_q == P_OVF, path_q == P_DZ);
                  rd_num_q  <= rd_lat_q;
                  done_q    <= 1'b1;
                  wb_out_q  <= wb_q;
                  state_q   <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o    = (state_q != S_IDLE);
   // Non-div instructions wait behind an in-flight divide; a div in DONE is accepted instead.
   assign bus.stall_o   = (state_q == S_PREP) | (state_q == S_ITER) | (state_q == S_FIX) |
                          (bus.v_i & ~bus.div_i & (state_q != S_IDLE) & (state_q != S_DONE));
   assign bus.done_o    = done_q;
   assign bus.wb_o      = wb_out_q;
   assign bus.rd_num_o  = rd_num_q;
   assign bus.rd_data_o = rd_data_q;
   assign bus.status_o  = status_q;
endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against an arithmetic reference model.
module tb_div_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_seq_if #(.WORD(32), .W_RD(5), .W_STATUS(4)) bus();
   div_seq #(.WORD(32), .W_RD(5), .W_STATUS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Result, flags and done latency (cycles after accept) straight from the divide rules.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input bit sg, input bit rm,
                        output logic [31:0] d, output logic [3:0] st, output int lat);
      bit v, dz;
      v = 1'b0;
      dz = 1'b0;
      if (b == 32'd0) begin
         dz = 1'b1;
         d = rm ? a : 32'hFFFF_FFFF;
         lat = 3;
      end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         v = 1'b1;
         d = rm ? 32'd0 : 32'h8000_0000;
         lat = 3;
      end else begin
         lat = 35;
         if (sg) d = rm ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
         else    d = rm ? a % b : a / b;
      end
      st = {d[31], d == 32'd0, v, dz};
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sg, input bit rm,
                        input logic [4:0] rd, input bit wb);
      bus.v_i = 1'b1; bus.div_i = 1'b1; bus.sgn_i = sg; bus.rem_i = rm;
      bus.dest_i = a; bus.src_i = b; bus.rd_num_i = rd; bus.wb_i = wb;
   endtask

   task automatic finish_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit sg, input bit rm, input logic [4:0] rd, input bit wb,
                             input bit nondiv_hold, input bit hold_check);
      logic [31:0] ed;
      logic [3:0]  es;
      int lat, got;
      bit stall_ok;
      model(a, b, sg, rm, ed, es, lat);
      @(posedge clk);
      #1;
      bus.v_i = nondiv_hold;
      bus.div_i = 1'b0;
      got = -1;
      stall_ok = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (bus.done_o === 1'b1) begin
            got = n;
            break;
         end
         if (bus.stall_o !== 1'b1 || bus.wb_o !== 1'b0) stall_ok = 1'b0;
      end
      check({tag, " latency"}, got, lat);
      check({tag, " stall"}, stall_ok, 1'b1);
      check({tag, " data"}, bus.rd_data_o, ed);
      check({tag, " status"}, bus.status_o, es);
      check({tag, " rd"}, bus.rd_num_o, rd);
      check({tag, " wb"}, bus.wb_o, wb);
      check({tag, " stall_done"}, bus.stall_o, 1'b0);
      bus.v_i = 1'b0;
      if (hold_check) begin
         @(negedge clk);
         check({tag, " done_drop"}, {bus.done_o, bus.wb_o, bus.busy_o}, 3'b000);
         check({tag, " hold"}, {bus.rd_data_o, bus.status_o, bus.rd_num_o}, {ed, es, rd});
      end
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input bit sg, input bit rm, input logic [4:0] rd, input bit wb);
      issue(a, b, sg, rm, rd, wb);
      finish_div(tag, a, b, sg, rm, rd, wb, 1'b0, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      bit sg, rm, wb, seen;
      logic [4:0] rd;
      bus.v_i = 1'b0; bus.div_i = 1'b0; bus.sgn_i = 1'b0; bus.rem_i = 1'b0;
      bus.dest_i = 32'd0; bus.src_i = 32'd0; bus.wb_i = 1'b0; bus.rd_num_i = 5'd0;
      bus.kill_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset outs", {bus.stall_o, bus.busy_o, bus.done_o, bus.wb_o, bus.rd_num_o,
                           bus.rd_data_o, bus.status_o}, 45'd0);
      rst = 1'b0;
      @(negedge clk);

      run("u_quo", 32'd100, 32'd7, 1'b0, 1'b0, 5'd3, 1'b1);
      run("u_rem", 32'd100, 32'd7, 1'b0, 1'b1, 5'd3, 1'b1);
      run("s_quo", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd4, 1'b1);
      run("s_rem", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 5'd4, 1'b0);
      run("s7_quo", 32'd7, 32'hFFFF_FFF9, 1'b1, 1'b0, 5'd5, 1'b1);
      run("s7_rem", 32'd7, 32'hFFFF_FFF9, 1'b1, 1'b1, 5'd5, 1'b1);
      run("dz_quo", 32'h1234, 32'd0, 1'b0, 1'b0, 5'd6, 1'b1);
      run("dz_rem", 32'h1234, 32'd0, 1'b0, 1'b1, 5'd6, 1'b1);
      run("ovf_quo", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd7, 1'b1);
      run("ovf_rem", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd7, 1'b1);

      // Second div presented in the DONE cycle of the first.
      issue(32'd1000, 32'd10, 1'b0, 1'b0, 5'd8, 1'b1);
      finish_div("b2b_a", 32'd1000, 32'd10, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      issue(32'd999, 32'd4, 1'b0, 1'b1, 5'd9, 1'b0);
      finish_div("b2b_b", 32'd999, 32'd4, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);

      issue(32'd100, 32'd7, 1'b0, 1'b0, 5'd10, 1'b1);
      finish_div("nondiv", 32'd100, 32'd7, 1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b1);

      // Flush in cycle 10 of a divide.
      issue(32'd1000, 32'd3, 1'b0, 1'b0, 5'd11, 1'b1);
      @(posedge clk);
      #1;
      bus.v_i = 1'b0; bus.div_i = 1'b0;
      repeat (10) @(negedge clk);
      bus.kill_i = 1'b1;
      @(posedge clk);
      #1;
      bus.kill_i = 1'b0;
      @(negedge clk);
      check("kill idle", {bus.busy_o, bus.stall_o, bus.done_o, bus.wb_o}, 4'b0000);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_o === 1'b1 || bus.wb_o === 1'b1) seen = 1'b1;
      end
      check("kill no_done", seen, 1'b0);
      run("post_kill", 32'd1000, 32'd3, 1'b0, 1'b0, 5'd12, 1'b1);

      // Reset while iterating clears every output.
      issue(32'd5000, 32'd9, 1'b0, 1'b0, 5'd13, 1'b1);
      @(posedge clk);
      #1;
      bus.v_i = 1'b0; bus.div_i = 1'b0;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst iter", {bus.stall_o, bus.busy_o, bus.done_o, bus.wb_o, bus.rd_num_o,
                         bus.rd_data_o, bus.status_o}, 45'd0);

      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            3:       b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         sg = $urandom_range(0, 1);
         rm = $urandom_range(0, 1);
         wb = $urandom_range(0, 1);
         rd = 5'($urandom_range(0, 31));
         issue(a, b, sg, rm, rd, wb);
         finish_div($sformatf("rnd%0d", i), a, b, sg, rm, rd, wb, 1'b0, 1'($urandom_range(0, 1)));
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
